// File: rtl/window_gen_kxk_pkg.sv
// Shared constants and elaboration helpers for the KxK window generator.
package window_gen_kxk_pkg;

  localparam int KSIZE_MAX  = 7;
  localparam int STRIDE_MIN = 1;
  localparam int STRIDE_MAX = 2;

  // Bits needed to hold 0..value-1; never less than 1.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  function automatic bit stride_is_legal(input int stride);
    return (stride == STRIDE_MIN) || (stride == STRIDE_MAX);
  endfunction

  // Element index of window position (i,j); multiply by DATA_WIDTH for the bit offset.
  function automatic int WIN_IDX(input int i, input int j, input int k);
    return i * k + j;
  endfunction

endpackage

// File: rtl/window_gen_kxk_if.sv
// Pixel stream in, flattened KxK window out; slave side is the window generator.
interface window_gen_kxk_if #(
  parameter int DATA_WIDTH = 32,
  parameter int KSIZE      = 3
);
  logic                                data_valid_in;
  logic                                frame_start_in;
  logic [DATA_WIDTH-1:0]               data_in;
  logic [KSIZE*KSIZE*DATA_WIDTH-1:0]   window_out;
  logic                                valid_out;
  logic                                frame_done;

  modport master (
    output data_valid_in, frame_start_in, data_in,
    input  window_out, valid_out, frame_done
  );

  modport slave (
    input  data_valid_in, frame_start_in, data_in,
    output window_out, valid_out, frame_done
  );
endinterface

// File: rtl/window_gen_kxk_line_buffer.sv
// Pixel delay line: dout is the pixel shifted in IMG_WIDTH enables earlier.
// Shifts only while en is high; contents hold otherwise.
module line_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 30
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DATA_WIDTH-1:0] mem_q [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] mem_d [IMG_WIDTH];

  always_comb begin
    mem_d = mem_q;
    if (en) begin
      mem_d[0] = din;
      for (int i = 1; i < IMG_WIDTH; i++) mem_d[i] = mem_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < IMG_WIDTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign dout = mem_q[IMG_WIDTH-1];
endmodule

// File: rtl/window_gen_kxk.sv
// KxK sliding-window generator with row/column tracking and stride; window, valid and
// frame_done register on the accepting edge. No back-pressure: one pixel per cycle max.
module window_gen_kxk
  import window_gen_kxk_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 30,
  parameter int IMG_HEIGHT = 30,
  parameter int KSIZE      = 3,
  parameter int STRIDE     = 1
) (
  input  logic      clk,
  input  logic      resetn,
  window_gen_kxk_if.slave win_if
);
  localparam int CW = clog2(IMG_WIDTH);
  localparam int RW = clog2(IMG_HEIGHT);
  localparam int PW = clog2(STRIDE);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] COL_K1   = CW'(KSIZE - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_K1   = RW'(KSIZE - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(STRIDE - 1);

  if (KSIZE < 2 || KSIZE > KSIZE_MAX) begin : g_bad_ksize
    $error("window_gen_kxk: KSIZE must be 2..%0d", KSIZE_MAX);
  end
  if (!stride_is_legal(STRIDE)) begin : g_bad_stride
    $error("window_gen_kxk: STRIDE must be 1 or 2");
  end
  if (IMG_WIDTH < KSIZE || IMG_HEIGHT < KSIZE) begin : g_bad_dims
    $error("window_gen_kxk: image smaller than kernel");
  end
  // The last pixel of a frame must land on a stride-aligned window.
  if (STRIDE == 2 && ((((IMG_WIDTH - KSIZE) & 1) != 0) || (((IMG_HEIGHT - KSIZE) & 1) != 0))) begin : g_bad_align
    $error("window_gen_kxk: IMG-KSIZE must be a multiple of STRIDE");
  end

  logic                  accept;
  logic                  qualify;
  logic [CW-1:0]         col_q, col_d, col_cur;
  logic [RW-1:0]         row_q, row_d, row_cur;
  logic [PW-1:0]         cph_q, cph_d, cph_cur;
  logic [PW-1:0]         rph_q, rph_d, rph_cur;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] win_q  [KSIZE][KSIZE];
  logic [DATA_WIDTH-1:0] win_d  [KSIZE][KSIZE];
  logic [DATA_WIDTH-1:0] lb_in  [KSIZE-1];
  logic [DATA_WIDTH-1:0] lb_out [KSIZE-1];
  logic [KSIZE*KSIZE*DATA_WIDTH-1:0] win_flat;

  assign accept = win_if.data_valid_in;

  for (genvar n = 0; n < KSIZE - 1; n++) begin : g_lb
    if (n == 0) begin : g_head
      assign lb_in[n] = win_if.data_in;
    end else begin : g_tail
      assign lb_in[n] = lb_out[n-1];
    end
    line_buffer #(
      .DATA_WIDTH(DATA_WIDTH),
      .IMG_WIDTH (IMG_WIDTH)
    ) u_line_buffer (
      .clk (clk),
      .rst (resetn),
      .en  (accept),
      .din (lb_in[n]),
      .dout(lb_out[n])
    );
  end

  // Position of the pixel being presented; frame_start forces (0,0).
  always_comb begin
    col_cur = col_q;
    row_cur = row_q;
    cph_cur = cph_q;
    rph_cur = rph_q;
    if (win_if.frame_start_in) begin
      col_cur = '0;
      row_cur = '0;
      cph_cur = '0;
      rph_cur = '0;
    end
    qualify = (col_cur >= COL_K1) && (row_cur >= ROW_K1) && (cph_cur == '0) && (rph_cur == '0);

    col_d   = col_q;
    row_d   = row_q;
    cph_d   = cph_q;
    rph_d   = rph_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    if (accept) begin
      valid_d = qualify;
      done_d  = qualify && (col_cur == COL_LAST) && (row_cur == ROW_LAST);
      if (col_cur == COL_LAST) begin
        col_d = '0;
        cph_d = '0;
        if (row_cur == ROW_LAST) begin
          row_d = '0;
          rph_d = '0;
        end else begin
          row_d = row_cur + 1'b1;
          rph_d = ((row_cur + 1'b1 == ROW_K1) || (rph_cur == PH_LAST)) ? '0 : rph_cur + 1'b1;
        end
      end else begin
        col_d = col_cur + 1'b1;
        row_d = row_cur;
        rph_d = rph_cur;
        cph_d = ((col_cur + 1'b1 == COL_K1) || (cph_cur == PH_LAST)) ? '0 : cph_cur + 1'b1;
      end
    end
  end

  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int i = 0; i < KSIZE; i++) begin
        for (int j = 0; j < KSIZE - 1; j++) win_d[i][j] = win_q[i][j+1];
      end
      for (int i = 0; i < KSIZE - 1; i++) win_d[i][KSIZE-1] = lb_out[KSIZE-2-i];
      win_d[KSIZE-1][KSIZE-1] = win_if.data_in;
    end
  end

  always_comb begin
    win_flat = '0;
    for (int i = 0; i < KSIZE; i++) begin
      for (int j = 0; j < KSIZE; j++) begin
        win_flat[WIN_IDX(i, j, KSIZE)*DATA_WIDTH +: DATA_WIDTH] = win_q[i][j];
      end
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      col_q   <= '0;
      row_q   <= '0;
      cph_q   <= '0;
      rph_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < KSIZE; i++) begin
        for (int j = 0; j < KSIZE; j++) win_q[i][j] <= '0;
      end
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      cph_q   <= cph_d;
      rph_q   <= rph_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      win_q   <= win_d;
    end
  end

  assign win_if.window_out = win_flat;
  assign win_if.valid_out  = valid_q;
  assign win_if.frame_done = done_q;
endmodule

// File: tb/tb_window_gen_kxk.sv
// Three generator configurations (5x4 K3 S1, 5x5 K3 S2, 6x6 K5 S1) driven with raster streams,
// checked by a per-instance scoreboard fed from an image-array reference model.
module tb_window_gen_kxk;
  logic        clk = 1'b0;
  logic        rst;
  logic        vld [3];
  logic        fs  [3];
  logic [31:0] din [3];
  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic int fw(input int g); return (g == 2) ? 6 : 5; endfunction
  function automatic int fh(input int g); return (g == 0) ? 4 : ((g == 1) ? 5 : 6); endfunction
  function automatic int fk(input int g); return (g == 2) ? 5 : 3; endfunction
  function automatic int fst(input int g); return (g == 1) ? 2 : 1; endfunction

  task automatic chk(input bit ok, input string name, input string detail);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int W  = fw(g);
    localparam int H  = fh(g);
    localparam int K  = fk(g);
    localparam int S  = fst(g);
    localparam int WW = K * K * 32;

    window_gen_kxk_if #(.DATA_WIDTH(32), .KSIZE(K)) ifc ();

    window_gen_kxk #(
      .DATA_WIDTH(32),
      .IMG_WIDTH (W),
      .IMG_HEIGHT(H),
      .KSIZE     (K),
      .STRIDE    (S)
    ) dut (
      .clk   (clk),
      .resetn(rst),
      .win_if(ifc)
    );

    assign ifc.data_valid_in  = vld[g];
    assign ifc.frame_start_in = fs[g];
    assign ifc.data_in        = din[g];

    logic [31:0]   img [H][W];
    logic [WW-1:0] exp_w_q [$];
    bit            exp_fd_q [$];
    logic [WW-1:0] win_log [$];
    int seen_win = 0;
    int seen_fd  = 0;

    // Reference: store each pixel at its (row,col); a window exists wherever a full KxK
    // block ends on a stride-aligned position.
    initial begin : model
      int mr, mc;
      logic [WW-1:0] w;
      mr = 0;
      mc = 0;
      forever begin
        @(posedge clk);
        if (rst) begin
          mr = 0;
          mc = 0;
          exp_w_q.delete();
          exp_fd_q.delete();
        end else if (vld[g]) begin
          if (fs[g]) begin
            mr = 0;
            mc = 0;
          end
          img[mr][mc] = din[g];
          if (mr >= K-1 && mc >= K-1 && (mr-(K-1)) % S == 0 && (mc-(K-1)) % S == 0) begin
            for (int i = 0; i < K; i++)
              for (int j = 0; j < K; j++)
                w[(i*K+j)*32 +: 32] = img[mr-(K-1)+i][mc-(K-1)+j];
            exp_w_q.push_back(w);
            exp_fd_q.push_back(mr == H-1 && mc == W-1);
          end
          mc++;
          if (mc == W) begin
            mc = 0;
            mr++;
            if (mr == H) mr = 0;
          end
        end
      end
    end

    initial begin : monitor
      logic [WW-1:0] prev_w, ew;
      bit acc, efd;
      prev_w = '0;
      forever begin
        @(posedge clk);
        acc = vld[g] && !rst;
        #1;
        if (rst) begin
          chk(ifc.window_out == '0 && !ifc.valid_out && !ifc.frame_done,
              $sformatf("reset_outputs[%0d]", g),
              $sformatf("valid=%b done=%b window=%h, want all zero", ifc.valid_out, ifc.frame_done, ifc.window_out));
        end else if (!acc) begin
          chk(!ifc.valid_out && !ifc.frame_done, $sformatf("gap_valid[%0d]", g),
              $sformatf("valid=%b done=%b after idle edge, want 0 0", ifc.valid_out, ifc.frame_done));
          chk(ifc.window_out == prev_w, $sformatf("gap_hold[%0d]", g),
              $sformatf("window %h changed from %h", ifc.window_out, prev_w));
        end else if (exp_w_q.size() == 0) begin
          chk(!ifc.valid_out && !ifc.frame_done, $sformatf("no_window[%0d]", g),
              $sformatf("valid=%b done=%b, want 0 0", ifc.valid_out, ifc.frame_done));
        end else begin
          ew  = exp_w_q.pop_front();
          efd = exp_fd_q.pop_front();
          chk(ifc.valid_out, $sformatf("window_valid[%0d]", g), "valid=0, want 1");
          chk(ifc.window_out == ew, $sformatf("window_data[%0d]", g),
              $sformatf("got %h want %h", ifc.window_out, ew));
          chk(ifc.frame_done == efd, $sformatf("frame_done[%0d]", g),
              $sformatf("got %b want %b", ifc.frame_done, efd));
        end
        if (ifc.valid_out) begin
          seen_win++;
          win_log.push_back(ifc.window_out);
        end
        if (ifc.frame_done) seen_fd++;
        prev_w = ifc.window_out;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        vld[g] = 1'b0;
        fs[g]  = 1'($urandom_range(0, 1));
        din[g] = $urandom;
      end
    end
  endtask

  // gmode: 0 = back-to-back, 1 = idle after every pixel, 2 = random idles.
  task automatic send(input int g, input int npix, input bit rnd_data, input int gmode,
                      input bit fs_first, input bit fs_rand);
    for (int k = 0; k < npix; k++) begin
      @(negedge clk);
      vld[g] = 1'b1;
      din[g] = rnd_data ? $urandom : 32'(k + 1);
      fs[g]  = (k == 0 && fs_first) || (fs_rand && $urandom_range(0, 24) == 0);
      if (gmode == 1 || (gmode == 2 && $urandom_range(0, 3) == 0)) begin
        @(negedge clk);
        vld[g] = 1'b0;
        fs[g]  = 1'($urandom_range(0, 1));
        din[g] = $urandom;
      end
    end
  endtask

  task automatic counts(input int g, output int w, output int f);
    case (g)
      0: begin w = g_inst[0].seen_win; f = g_inst[0].seen_fd; end
      1: begin w = g_inst[1].seen_win; f = g_inst[1].seen_fd; end
      default: begin w = g_inst[2].seen_win; f = g_inst[2].seen_fd; end
    endcase
  endtask

  task automatic expect_counts(input int g, input int w0, input int f0, input int ew, input int ef,
                               input string tag);
    int w1, f1;
    idle(4);
    counts(g, w1, f1);
    chk(w1 - w0 == ew, {tag, "_windows"}, $sformatf("got %0d windows want %0d", w1 - w0, ew));
    chk(f1 - f0 == ef, {tag, "_frame_done"}, $sformatf("got %0d pulses want %0d", f1 - f0, ef));
  endtask

  initial begin : driver
    int w0, f0, base;
    int first_exp[9] = '{1, 2, 3, 6, 7, 8, 11, 12, 13};
    logic [287:0] lw3;
    logic [799:0] lw5;

    rst = 1'b1;
    for (int g = 0; g < 3; g++) begin
      vld[g] = 1'b0;
      fs[g]  = 1'b0;
      din[g] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Basic 5x4 K3 S1 frame; first window is rows {1,2,3},{6,7,8},{11,12,13}.
    counts(0, w0, f0);
    base = g_inst[0].win_log.size();
    send(0, 20, 1'b0, 0, 1'b1, 1'b0);
    expect_counts(0, w0, f0, 6, 1, "basic");
    if (g_inst[0].win_log.size() > base) begin
      lw3 = g_inst[0].win_log[base];
      for (int j = 0; j < 9; j++)
        chk(lw3[j*32 +: 32] == 32'(first_exp[j]), $sformatf("first_window_elem%0d", j),
            $sformatf("got %0d want %0d", lw3[j*32 +: 32], first_exp[j]));
    end else begin
      chk(1'b0, "first_window_present", "no window logged");
    end

    counts(0, w0, f0);
    send(0, 20, 1'b0, 1, 1'b1, 1'b0);
    expect_counts(0, w0, f0, 6, 1, "gapped");

    counts(0, w0, f0);
    send(0, 20, 1'b0, 0, 1'b1, 1'b0);
    send(0, 20, 1'b0, 0, 1'b0, 1'b0);
    expect_counts(0, w0, f0, 12, 2, "back_to_back");

    // Restart on the 9th pixel abandons the partial frame.
    counts(0, w0, f0);
    send(0, 8, 1'b0, 0, 1'b1, 1'b0);
    send(0, 20, 1'b0, 0, 1'b1, 1'b0);
    expect_counts(0, w0, f0, 6, 1, "restart");

    // Two-cycle reset mid-frame with pixels still offered.
    send(0, 12, 1'b0, 0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    vld[0] = 1'b1;
    din[0] = $urandom;
    @(negedge clk);
    din[0] = $urandom;
    @(negedge clk);
    rst = 1'b0;
    vld[0] = 1'b0;
    counts(0, w0, f0);
    send(0, 20, 1'b0, 0, 1'b0, 1'b0);
    expect_counts(0, w0, f0, 6, 1, "after_reset");

    counts(1, w0, f0);
    send(1, 25, 1'b0, 0, 1'b1, 1'b0);
    expect_counts(1, w0, f0, 4, 1, "stride2");
    counts(1, w0, f0);
    send(1, 25, 1'b1, 2, 1'b1, 1'b0);
    expect_counts(1, w0, f0, 4, 1, "stride2_random");

    counts(2, w0, f0);
    base = g_inst[2].win_log.size();
    send(2, 36, 1'b0, 0, 1'b1, 1'b0);
    expect_counts(2, w0, f0, 4, 1, "k5");
    if (g_inst[2].win_log.size() > base) begin
      lw5 = g_inst[2].win_log[base];
      chk(lw5[0 +: 32] == 32'd1, "k5_elem00", $sformatf("got %0d want 1", lw5[0 +: 32]));
      chk(lw5[24*32 +: 32] == 32'd29, "k5_elem44", $sformatf("got %0d want 29", lw5[24*32 +: 32]));
    end else begin
      chk(1'b0, "k5_window_present", "no window logged");
    end

    // Random data, random gaps and occasional mid-frame restarts.
    send(0, 120, 1'b1, 2, 1'b1, 1'b1);
    send(2, 72, 1'b1, 2, 1'b1, 1'b1);
    idle(5);

    chk(g_inst[0].exp_w_q.size() == 0, "pending_windows[0]",
        $sformatf("%0d expected windows never produced", g_inst[0].exp_w_q.size()));
    chk(g_inst[1].exp_w_q.size() == 0, "pending_windows[1]",
        $sformatf("%0d expected windows never produced", g_inst[1].exp_w_q.size()));
    chk(g_inst[2].exp_w_q.size() == 0, "pending_windows[2]",
        $sformatf("%0d expected windows never produced", g_inst[2].exp_w_q.size()));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
